// File: rtl/unpack_pkg.sv
// Shared constants and types for the word-to-byte unpacker.
// State encoding, default widths and the derived lane/index sizes.
package unpack_pkg;

   function automatic int idx_bits(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   localparam int WORD_WIDTH_DEF = 32;
   localparam int BYTE_WIDTH_DEF = 8;
   localparam int RATIO = WORD_WIDTH_DEF / BYTE_WIDTH_DEF;
   localparam int IDX_WIDTH = idx_bits(RATIO);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1
   } state_t;

endpackage

// File: rtl/unpack_byte_mux.sv
// Selects one BYTE_WIDTH lane of a word by lane index.
// Lane 0 is the least-significant byte.
module unpack_byte_mux #(
   parameter int WORD_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int IDX_WIDTH  = 2
) (
   input  logic [WORD_WIDTH-1:0] word,
   input  logic [IDX_WIDTH-1:0]  idx,
   output logic [BYTE_WIDTH-1:0] sym
);

   localparam int LANES = WORD_WIDTH / BYTE_WIDTH;

   // one-hot compare per lane keeps out-of-range indices at zero
   always_comb begin
      sym = '0;
      for (int i = 0; i < LANES; i++) begin
         if (idx == IDX_WIDTH'(i)) begin
            sym = word[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

endmodule

// File: rtl/word_unpacker.sv
// Pops words from a FWFT FIFO and pushes them LSB-first as bytes.
// Optional counters are built when UNPACK_STATS_EN is defined.
module word_unpacker
   import unpack_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  fifo_in_rd_en,
   input  logic [WORD_WIDTH-1:0] fifo_in_dout,
   input  logic                  fifo_in_empty,
   output logic                  fifo_out_wr_en,
   output logic [BYTE_WIDTH-1:0] fifo_out_din,
   input  logic                  fifo_out_full
`ifdef UNPACK_STATS_EN
   ,
   output logic [31:0]           byte_count,
   output logic [31:0]           word_count
`endif
);

   localparam int LANES = WORD_WIDTH / BYTE_WIDTH;
   localparam int IW = idx_bits(LANES);
   localparam logic [IW-1:0] LAST = IW'(LANES - 1);

   state_t                state;
   state_t                state_nx;
   logic [WORD_WIDTH-1:0] word;
   logic [WORD_WIDTH-1:0] word_nx;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_nx;
   logic                  rd;
   logic                  wr;
   logic [BYTE_WIDTH-1:0] sym;

   unpack_byte_mux #(
      .WORD_WIDTH (WORD_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH),
      .IDX_WIDTH  (IW)
   ) u_mux (
      .word (word),
      .idx  (idx),
      .sym  (sym)
   );

   // state, held word and lane index registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         word  <= '0;
         idx   <= '0;
      end else begin
         state <= state_nx;
         word  <= word_nx;
         idx   <= idx_nx;
      end
   end

   // next-state and handshake decode; last byte may overlap next pop
   always_comb begin
      state_nx = state;
      word_nx  = word;
      idx_nx   = idx;
      rd       = 1'b0;
      wr       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_in_empty) begin
               rd       = 1'b1;
               word_nx  = fifo_in_dout;
               idx_nx   = '0;
               state_nx = S_EMIT;
            end
         end
         S_EMIT: begin
            if (!fifo_out_full) begin
               wr = 1'b1;
               if (idx == LAST) begin
                  if (!fifo_in_empty) begin
                     rd      = 1'b1;
                     word_nx = fifo_in_dout;
                     idx_nx  = '0;
                  end else begin
                     state_nx = S_IDLE;
                  end
               end else begin
                  idx_nx = idx + IW'(1);
               end
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // outputs forced quiet while reset is held
   always_comb begin
      fifo_in_rd_en  = reset ? 1'b0 : rd;
      fifo_out_wr_en = reset ? 1'b0 : wr;
      fifo_out_din   = reset ? '0 : sym;
   end

`ifdef UNPACK_STATS_EN
   // free-running traffic counters, wrap at 2^32
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         byte_count <= '0;
         word_count <= '0;
      end else begin
         if (wr) byte_count <= byte_count + 32'd1;
         if (rd) word_count <= word_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_word_unpacker.sv
// Directed and randomized bench for word_unpacker.
// Reference: queue of expected bytes from LSB-first word expansion.
module tb_word_unpacker;
   import unpack_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        fifo_in_rd_en;
   logic [31:0] fifo_in_dout;
   logic        fifo_in_empty;
   logic        fifo_out_wr_en;
   logic [7:0]  fifo_out_din;
   logic        fifo_out_full;
`ifdef UNPACK_STATS_EN
   logic [31:0] byte_count;
   logic [31:0] word_count;
`endif

   word_unpacker #(
      .WORD_WIDTH (32),
      .BYTE_WIDTH (8)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .fifo_in_rd_en  (fifo_in_rd_en),
      .fifo_in_dout   (fifo_in_dout),
      .fifo_in_empty  (fifo_in_empty),
      .fifo_out_wr_en (fifo_out_wr_en),
      .fifo_out_din   (fifo_out_din),
      .fifo_out_full  (fifo_out_full)
`ifdef UNPACK_STATS_EN
      ,
      .byte_count     (byte_count),
      .word_count     (word_count)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [31:0] in_q[$];
   logic [7:0]  exp_q[$];

   logic       obs_rd;
   logic       obs_wr;
   logic [7:0] obs_din;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock: drive at negedge, check, then advance the model
   task automatic cycle(input bit full_i, input bit hide_i);
      bit exp_rd;
      bit exp_wr;
      logic [31:0] w;
      @(negedge clock);
      fifo_out_full = full_i;
      fifo_in_empty = hide_i || (in_q.size() == 0);
      fifo_in_dout  = (in_q.size() != 0) ? in_q[0] : 32'h0;
      #1;
      exp_wr = (exp_q.size() > 0) && !full_i;
      exp_rd = !fifo_in_empty &&
               ((exp_q.size() == 0) ||
                (exp_q.size() == 1 && !full_i));
      obs_rd  = fifo_in_rd_en;
      obs_wr  = fifo_out_wr_en;
      obs_din = fifo_out_din;
      chk("rd_en", {31'b0, obs_rd}, {31'b0, exp_rd});
      chk("wr_en", {31'b0, obs_wr}, {31'b0, exp_wr});
      if (exp_wr && obs_wr) begin
         chk("din", {24'b0, obs_din}, {24'b0, exp_q[0]});
      end
      @(posedge clock);
      if (exp_wr) void'(exp_q.pop_front());
      if (exp_rd) begin
         w = in_q.pop_front();
         for (int k = 0; k < RATIO; k++) begin
            exp_q.push_back(8'((w >> (8 * k)) & 32'hFF));
         end
      end
      cyc++;
   endtask

   int rd_n;
   int wr_n;
   int rd_cyc[$];
   int wr_cyc[$];
   logic [31:0] got;

   task automatic clear_log();
      rd_n = 0;
      wr_n = 0;
      rd_cyc.delete();
      wr_cyc.delete();
      got = '0;
   endtask

   task automatic log_cycle(input bit full_i, input bit hide_i);
      int c;
      c = cyc;
      cycle(full_i, hide_i);
      if (obs_rd) begin
         rd_n++;
         rd_cyc.push_back(c);
      end
      if (obs_wr) begin
         if (wr_n < 4) got[8*wr_n +: 8] = obs_din;
         wr_n++;
         wr_cyc.push_back(c);
      end
   endtask

   initial begin
      int pushed;
      int guard;
      reset         = 1'b1;
      fifo_in_empty = 1'b0;
      fifo_in_dout  = 32'hDEADBEEF;
      fifo_out_full = 1'b0;
      #1;
      chk("rst_rd", {31'b0, fifo_in_rd_en}, 32'd0);
      chk("rst_wr", {31'b0, fifo_out_wr_en}, 32'd0);
      chk("rst_din", {24'b0, fifo_out_din}, 32'd0);
      fifo_in_empty = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_state", {30'b0, dut.state}, 32'd0);
      chk("rst_idx", {30'b0, dut.idx}, 32'd0);

      // single isolated word
      clear_log();
      in_q.push_back(32'h44332211);
      repeat (7) log_cycle(1'b0, 1'b0);
      chk("single_rd_n", rd_n, 1);
      chk("single_wr_n", wr_n, 4);
      chk("single_bytes", got, 32'h44332211);
      chk("single_lat", wr_cyc[0] - rd_cyc[0], 1);
      chk("single_span", wr_cyc[3] - wr_cyc[0], 3);

      // three preloaded words, no bubbles
      clear_log();
      in_q.push_back(32'hA3A2A1A0);
      in_q.push_back(32'hB3B2B1B0);
      in_q.push_back(32'hC3C2C1C0);
      repeat (15) log_cycle(1'b0, 1'b0);
      chk("three_rd_n", rd_n, 3);
      chk("three_wr_n", wr_n, 12);
      chk("three_rd1", rd_cyc[1] - rd_cyc[0], 4);
      chk("three_rd2", rd_cyc[2] - rd_cyc[0], 8);
      chk("three_span", wr_cyc[11] - wr_cyc[0], 11);
      chk("three_lat", wr_cyc[0] - rd_cyc[0], 1);

      // backpressure after second byte
      clear_log();
      in_q.push_back(32'h0D0C0B0A);
      log_cycle(1'b0, 1'b0);
      log_cycle(1'b0, 1'b0);
      log_cycle(1'b0, 1'b0);
      repeat (3) begin
         log_cycle(1'b1, 1'b0);
         chk("bp_no_wr", {31'b0, obs_wr}, 32'd0);
      end
      log_cycle(1'b0, 1'b0);
      chk("bp_resume", {24'b0, obs_din}, 32'h0C);
      repeat (3) log_cycle(1'b0, 1'b0);
      chk("bp_wr_n", wr_n, 4);
      chk("bp_bytes", got, 32'h0D0C0B0A);

      // starvation between words
      clear_log();
      in_q.push_back(32'h87654321);
      repeat (5) log_cycle(1'b0, 1'b0);
      repeat (5) log_cycle(1'b0, 1'b0);
      chk("starve_idle", {30'b0, dut.state}, 32'd0);
      chk("starve_rd_n", rd_n, 1);
      in_q.push_back(32'hFEDCBA98);
      repeat (6) log_cycle(1'b0, 1'b0);
      chk("starve_rd_n2", rd_n, 2);
      chk("starve_wr_n", wr_n, 8);

      // reset mid-word
      in_q.push_back(32'h13579BDF);
      repeat (2) cycle(1'b0, 1'b0);
      #2;
      fifo_in_empty = 1'b0;
      fifo_in_dout  = 32'h5A5A5A5A;
      reset = 1'b1;
      #1;
      chk("mid_rst_rd", {31'b0, fifo_in_rd_en}, 32'd0);
      chk("mid_rst_wr", {31'b0, fifo_out_wr_en}, 32'd0);
      chk("mid_rst_din", {24'b0, fifo_out_din}, 32'd0);
      exp_q.delete();
      fifo_in_empty = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("mid_state", {30'b0, dut.state}, 32'd0);
      chk("mid_idx", {30'b0, dut.idx}, 32'd0);
      chk("mid_din", {24'b0, fifo_out_din}, 32'd0);

      // random traffic: 100 words, random full/empty
      pushed = 0;
      guard  = 0;
      while ((pushed < 100 || in_q.size() > 0 || exp_q.size() > 0)
             && guard < 5000) begin
         if (pushed < 100 && $urandom_range(0, 2) == 0) begin
            in_q.push_back($urandom);
            pushed++;
         end
         cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
         guard++;
      end
      chk("rand_drain", in_q.size() + exp_q.size() + (100 - pushed), 0);
`ifdef UNPACK_STATS_EN
      chk("byte_count", byte_count, 32'd400);
      chk("word_count", word_count, 32'd100);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
